// File: rtl/fir_coeff_loader_if.sv
// Configuration stream carrying coefficient words into the loader.
// The bus side drives words; the loader drives back-pressure.
interface fir_coeff_loader_if #(
    parameter int CBITS = 16
);
    logic             cfg_valid_in;
    logic [CBITS-1:0] cfg_data_in;
    logic             cfg_last_in;
    logic             cfg_ready_out;

    modport master (
        output cfg_valid_in,
        output cfg_data_in,
        output cfg_last_in,
        input  cfg_ready_out
    );

    modport slave (
        input  cfg_valid_in,
        input  cfg_data_in,
        input  cfg_last_in,
        output cfg_ready_out
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the FIR filter unit.
// Collects one frame of NTAPS coefficient words into a shadow bank and
// strobes load_en_out only when the filter is stopped or has just produced
// a sample, so the filter never sees a half-updated coefficient set.
module fir_coeff_loader #(
    parameter int NTAPS   = 7,
    parameter int CBITS   = 16,
    parameter int TMOBITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fir_coeff_loader_if.slave      cfg,
    input  logic                   run_in,
    input  logic                   dvalid_in,
    output logic [NTAPS*CBITS-1:0] coeffs_out,
    output logic                   load_en_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   err_out
);
    localparam int IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [NTAPS*CBITS-1:0] bank_q, bank_d;
    logic [TMOBITS-1:0]     tmo_q, tmo_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    logic                   ready_s;
    logic                   accept_s;
    logic [TMOBITS-1:0]     tmo_inc_s;

    // Ready is held low while reset is asserted so the bus sees no acceptance window
    assign ready_s   = rst_n && ((state_q == IDLE) || (state_q == FILL));
    assign accept_s  = cfg.cfg_valid_in && ready_s;
    assign tmo_inc_s = tmo_q + 1'b1;

    assign cfg.cfg_ready_out = ready_s;
    assign coeffs_out        = bank_q;
    assign err_out           = err_q;
    assign done_out          = done_q;

    // Next-state logic: frame assembly, safe-point wait and load strobe
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        tmo_d       = '0;
        err_d       = 1'b0;
        done_d      = 1'b0;
        busy_out    = 1'b0;
        load_en_out = 1'b0;

        if (accept_s) begin
            bank_d[idx_q*CBITS +: CBITS] = cfg.cfg_data_in;
        end

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (accept_s) begin
                    if (NTAPS == 1) begin
                        if (cfg.cfg_last_in) begin
                            state_d = ARMED;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cfg.cfg_last_in) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = IDXW'(1);
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                busy_out = 1'b1;
                if (accept_s) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (cfg.cfg_last_in) begin
                            state_d = ARMED;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (cfg.cfg_last_in) begin
                        idx_d   = '0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ARMED: begin
                busy_out = 1'b1;
                if (!run_in || dvalid_in) begin
                    state_d = LOAD;
                end else if (tmo_inc_s == '1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            LOAD: begin
                busy_out    = 1'b1;
                load_en_out = 1'b1;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset that discards any pending frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bank_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bank_q  <= bank_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with NTAPS=7, CBITS=16, TMOBITS=8.
module tb_fir_coeff_loader;
    localparam int NTAPS = 7;
    localparam int CBITS = 16;

    logic                   clk;
    logic                   rst_n;
    logic                   run_in;
    logic                   dvalid_in;
    logic [NTAPS*CBITS-1:0] coeffs_out;
    logic                   load_en_out;
    logic                   busy_out;
    logic                   done_out;
    logic                   err_out;

    int checks;
    int errors;
    int loadCount;
    int errCount;

    logic [CBITS-1:0]       frameWords [NTAPS];
    logic [NTAPS*CBITS-1:0] expBank;

    fir_coeff_loader_if #(.CBITS(CBITS)) cfgIf ();

    fir_coeff_loader #(
        .NTAPS  (NTAPS),
        .CBITS  (CBITS),
        .TMOBITS(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfgIf.slave),
        .run_in     (run_in),
        .dvalid_in  (dvalid_in),
        .coeffs_out (coeffs_out),
        .load_en_out(load_en_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .err_out    (err_out)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobes at the falling edge, away from the active edge
    always @(negedge clk) begin
        if (load_en_out === 1'b1) loadCount++;
        if (err_out === 1'b1) errCount++;
    end

    // Hard time limit so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one word after gap idle cycles; tasks start and end 1ns after a rising edge
    task automatic sendWord(input logic [CBITS-1:0] d, input logic l, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        cfgIf.cfg_valid_in = 1'b1;
        cfgIf.cfg_data_in  = d;
        cfgIf.cfg_last_in  = l;
        checks++;
        if (cfgIf.cfg_ready_out !== 1'b1) begin
            $display("[TB] FAIL word_ready: ready=%b required 1", cfgIf.cfg_ready_out);
            errors++;
        end
        @(posedge clk);
        #1;
        cfgIf.cfg_valid_in = 1'b0;
        cfgIf.cfg_last_in  = 1'b0;
    endtask

    // Send frameWords[0..nWords-1], marking last on word lastAt (-1 for none)
    task automatic sendFrame(input int nWords, input int lastAt, input int gap);
        for (int k = 0; k < nWords; k++) begin
            sendWord(frameWords[k], (k == lastAt), gap);
        end
    endtask

    // Build the expected bank from frameWords, word 0 in the LSBs
    task automatic buildExpected();
        for (int k = 0; k < NTAPS; k++) begin
            expBank[k*CBITS +: CBITS] = frameWords[k];
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({cfgIf.cfg_ready_out, load_en_out, busy_out, done_out, err_out} !== 5'b0) begin
            $display("[TB] FAIL reset_outputs: got %b required 00000",
                     {cfgIf.cfg_ready_out, load_en_out, busy_out, done_out, err_out});
            errors++;
        end
        checks++;
        if (coeffs_out !== '0) begin
            $display("[TB] FAIL reset_coeffs: got %h required 0", coeffs_out);
            errors++;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cfgIf.cfg_ready_out !== 1'b1) begin
            $display("[TB] FAIL reset_release_ready: got %b required 1", cfgIf.cfg_ready_out);
            errors++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_load();
        int loads0;
        loads0 = loadCount;
        frameWords = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0004, 16'h0002, 16'h0001};
        sendFrame(NTAPS, NTAPS - 1, 0);
        checks++;
        if (load_en_out !== 1'b0 || cfgIf.cfg_ready_out !== 1'b0 || busy_out !== 1'b1) begin
            $display("[TB] FAIL basic_armed: load=%b ready=%b busy=%b required 0 0 1",
                     load_en_out, cfgIf.cfg_ready_out, busy_out);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (load_en_out !== 1'b1) begin
            $display("[TB] FAIL basic_load_en: got %b required 1", load_en_out);
            errors++;
        end
        checks++;
        if (coeffs_out !== 112'h0001_0002_0004_0008_0004_0002_0001) begin
            $display("[TB] FAIL basic_coeffs: got %h required 0001000200040008000400020001", coeffs_out);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (load_en_out !== 1'b0 || done_out !== 1'b1 || cfgIf.cfg_ready_out !== 1'b1 || err_out !== 1'b0) begin
            $display("[TB] FAIL basic_done: load=%b done=%b ready=%b err=%b required 0 1 1 0",
                     load_en_out, done_out, cfgIf.cfg_ready_out, err_out);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_out !== 1'b0 || loadCount != loads0 + 1) begin
            $display("[TB] FAIL basic_single_pulse: done=%b loads=%0d required 0 %0d",
                     done_out, loadCount - loads0, 1);
            errors++;
        end
    endtask

    task automatic test_running_filter();
        int loads0;
        int waitErr;
        loads0  = loadCount;
        waitErr = 0;
        run_in  = 1'b1;
        frameWords = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
        sendFrame(NTAPS, NTAPS - 1, 0);
        for (int i = 0; i < 10; i++) begin
            if (cfgIf.cfg_ready_out !== 1'b0 || load_en_out !== 1'b0 || busy_out !== 1'b1) waitErr++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (waitErr != 0) begin
            $display("[TB] FAIL running_wait: %0d bad wait cycles required 0", waitErr);
            errors++;
        end
        dvalid_in = 1'b1;
        @(posedge clk);
        #1;
        dvalid_in = 1'b0;
        checks++;
        if (load_en_out !== 1'b1) begin
            $display("[TB] FAIL running_load_en: got %b required 1", load_en_out);
            errors++;
        end
        checks++;
        if (coeffs_out !== 112'h7777_6666_5555_4444_3333_2222_1111) begin
            $display("[TB] FAIL running_coeffs: got %h required 7777666655554444333322221111", coeffs_out);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (load_en_out !== 1'b0 || done_out !== 1'b1 || loadCount != loads0 + 1) begin
            $display("[TB] FAIL running_done: load=%b done=%b loads=%0d required 0 1 1",
                     load_en_out, done_out, loadCount - loads0);
            errors++;
        end
        run_in = 1'b0;
    endtask

    task automatic test_short_frame();
        int loads0;
        int errs0;
        loads0 = loadCount;
        errs0  = errCount;
        frameWords = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006};
        sendFrame(4, 3, 0);
        checks++;
        if (err_out !== 1'b1 || busy_out !== 1'b0 || cfgIf.cfg_ready_out !== 1'b1) begin
            $display("[TB] FAIL short_err: err=%b busy=%b ready=%b required 1 0 1",
                     err_out, busy_out, cfgIf.cfg_ready_out);
            errors++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (loadCount != loads0 || errCount != errs0 + 1) begin
            $display("[TB] FAIL short_counts: loads=%0d errs=%0d required 0 1",
                     loadCount - loads0, errCount - errs0);
            errors++;
        end
        frameWords = '{16'hB100, 16'hB201, 16'hB302, 16'hB403, 16'hB504, 16'hB605, 16'hB706};
        buildExpected();
        sendFrame(NTAPS, NTAPS - 1, 0);
        @(posedge clk);
        #1;
        checks++;
        if (load_en_out !== 1'b1 || coeffs_out !== expBank) begin
            $display("[TB] FAIL short_recover: load=%b coeffs=%h required 1 %h",
                     load_en_out, coeffs_out, expBank);
            errors++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_long_frame();
        int loads0;
        loads0 = loadCount;
        frameWords = '{16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'hC006};
        sendFrame(NTAPS, -1, 0);
        checks++;
        if (err_out !== 1'b1 || cfgIf.cfg_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            $display("[TB] FAIL long_err: err=%b ready=%b busy=%b required 1 1 0",
                     err_out, cfgIf.cfg_ready_out, busy_out);
            errors++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (loadCount != loads0 || err_out !== 1'b0) begin
            $display("[TB] FAIL long_no_load: loads=%0d err=%b required 0 0", loadCount - loads0, err_out);
            errors++;
        end
    endtask

    task automatic test_timeout();
        int loads0;
        int n;
        loads0 = loadCount;
        n      = 0;
        run_in = 1'b1;
        frameWords = '{16'hD000, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005, 16'hD006};
        sendFrame(NTAPS, NTAPS - 1, 0);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (err_out === 1'b1) break;
        end
        checks++;
        if (err_out !== 1'b1 || n != 255) begin
            $display("[TB] FAIL timeout_cycles: err=%b after %0d cycles required 1 after 255", err_out, n);
            errors++;
        end
        checks++;
        if (busy_out !== 1'b0 || loadCount != loads0) begin
            $display("[TB] FAIL timeout_no_load: busy=%b loads=%0d required 0 0", busy_out, loadCount - loads0);
            errors++;
        end
        run_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        int loads0;
        loads0 = loadCount;
        frameWords = '{16'hE000, 16'hE001, 16'hE002, 16'hE003, 16'hE004, 16'hE005, 16'hE006};
        sendFrame(3, -1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({cfgIf.cfg_ready_out, load_en_out, busy_out, done_out, err_out} !== 5'b0 || coeffs_out !== '0) begin
            $display("[TB] FAIL midframe_reset: outs=%b coeffs=%h required 00000 0",
                     {cfgIf.cfg_ready_out, load_en_out, busy_out, done_out, err_out}, coeffs_out);
            errors++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_in = 1'b1;
        sendFrame(NTAPS, NTAPS - 1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({cfgIf.cfg_ready_out, load_en_out, busy_out, done_out, err_out} !== 5'b0 || coeffs_out !== '0) begin
            $display("[TB] FAIL armed_reset: outs=%b coeffs=%h required 00000 0",
                     {cfgIf.cfg_ready_out, load_en_out, busy_out, done_out, err_out}, coeffs_out);
            errors++;
        end
        rst_n  = 1'b1;
        run_in = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (loadCount != loads0 || busy_out !== 1'b0) begin
            $display("[TB] FAIL reset_no_load: loads=%0d busy=%b required 0 0", loadCount - loads0, busy_out);
            errors++;
        end
        frameWords = '{16'h0F0F, 16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 16'h5A5A, 16'hBEEF};
        buildExpected();
        sendFrame(NTAPS, NTAPS - 1, 2);
        @(posedge clk);
        #1;
        checks++;
        if (load_en_out !== 1'b1 || coeffs_out !== expBank) begin
            $display("[TB] FAIL fresh_gapped_frame: load=%b coeffs=%h required 1 %h",
                     load_en_out, coeffs_out, expBank);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_out !== 1'b1 || loadCount != loads0 + 1) begin
            $display("[TB] FAIL fresh_done: done=%b loads=%0d required 1 1", done_out, loadCount - loads0);
            errors++;
        end
    endtask

    // Scenario sequence
    initial begin
        checks             = 0;
        errors             = 0;
        loadCount          = 0;
        errCount           = 0;
        rst_n              = 1'b0;
        run_in             = 1'b0;
        dvalid_in          = 1'b0;
        cfgIf.cfg_valid_in = 1'b0;
        cfgIf.cfg_data_in  = '0;
        cfgIf.cfg_last_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic_load();
        test_running_filter();
        test_short_frame();
        test_long_frame();
        test_timeout();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
